// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port.
// Two sources (EXU, LSU) each feed a one-entry holding buffer. A round-robin
// grant moves one buffer per cycle into a registered write port. A
// combinational hazard query reports source registers with a write in flight.

// One-entry writeback holding buffer with a valid/ready handshake.
// A granted entry leaves at the edge. A handshake in the same cycle refills
// the buffer at that same edge. Requests that target x0 complete the
// handshake but are never stored.
module regfile_wb_slot #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_grant,
  output logic              o_v,
  output logic [ADDR_W-1:0] o_rd,
  output logic [DATA_W-1:0] o_data
);

  logic              r_v;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;
  logic              w_hs;
  logic              w_load;

  // Ready comes only from registered state and the grant, never from i_valid.
  always_comb begin
    o_ready = !r_v || i_grant;
    w_hs    = i_valid && o_ready;
    w_load  = w_hs && (i_rd != '0);
  end

  // Buffer occupancy: a load has priority over a drain, so grant and load in
  // the same cycle leave the buffer full with the new request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v    <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else if (w_load) begin
      r_v    <= 1'b1;
      r_rd   <= i_rd;
      r_data <= i_data;
    end else if (i_grant) begin
      r_v    <= 1'b0;
    end
  end

  assign o_v    = r_v;
  assign o_rd   = r_rd;
  assign o_data = r_data;

endmodule

module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [ADDR_W-1:0] exu_rd,
  input  logic [DATA_W-1:0] exu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              reg_wen,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] reg_in,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              hit1,
  output logic              hit2,
  output logic              idle
);

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  src_e              r_last;
  logic              r_wen;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;

  logic              w_exu_v;
  logic [ADDR_W-1:0] w_exu_rd;
  logic [DATA_W-1:0] w_exu_data;
  logic              w_lsu_v;
  logic [ADDR_W-1:0] w_lsu_rd;
  logic [DATA_W-1:0] w_lsu_data;
  logic              w_gnt_exu;
  logic              w_gnt_lsu;

  regfile_wb_slot #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_exu_slot (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_valid (exu_valid),
    .o_ready (exu_ready),
    .i_rd    (exu_rd),
    .i_data  (exu_data),
    .i_grant (w_gnt_exu),
    .o_v     (w_exu_v),
    .o_rd    (w_exu_rd),
    .o_data  (w_exu_data)
  );

  regfile_wb_slot #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_lsu_slot (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_valid (lsu_valid),
    .o_ready (lsu_ready),
    .i_rd    (lsu_rd),
    .i_data  (lsu_data),
    .i_grant (w_gnt_lsu),
    .o_v     (w_lsu_v),
    .o_rd    (w_lsu_rd),
    .o_data  (w_lsu_data)
  );

  // Round-robin grant: a lone valid buffer wins, otherwise the source not
  // granted most recently wins.
  always_comb begin
    w_gnt_exu = w_exu_v && (!w_lsu_v || (r_last == SRC_LSU));
    w_gnt_lsu = w_lsu_v && (!w_exu_v || (r_last == SRC_EXU));
  end

  // Remember the most recent grant for the next contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= SRC_LSU;
    end else if (w_gnt_exu) begin
      r_last <= SRC_EXU;
    end else if (w_gnt_lsu) begin
      r_last <= SRC_LSU;
    end
  end

  // Registered write port. Index and data hold while no write is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wen  <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else if (w_gnt_exu) begin
      r_wen  <= 1'b1;
      r_rd   <= w_exu_rd;
      r_data <= w_exu_data;
    end else if (w_gnt_lsu) begin
      r_wen  <= 1'b1;
      r_rd   <= w_lsu_rd;
      r_data <= w_lsu_data;
    end else begin
      r_wen  <= 1'b0;
    end
  end

  assign reg_wen = r_wen;
  assign rd      = r_rd;
  assign reg_in  = r_data;

  // Hazard query: a source register is pending from buffer load through the
  // cycle its write is presented to the register file. x0 is never pending.
  always_comb begin
    hit1 = (rs1 != '0) &&
           ((w_exu_v && (w_exu_rd == rs1)) ||
            (w_lsu_v && (w_lsu_rd == rs1)) ||
            (r_wen   && (r_rd     == rs1)));
    hit2 = (rs2 != '0) &&
           ((w_exu_v && (w_exu_rd == rs2)) ||
            (w_lsu_v && (w_lsu_rd == rs2)) ||
            (r_wen   && (r_rd     == rs2)));
    idle = !w_exu_v && !w_lsu_v && !r_wen;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expected values.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          exu_valid, exu_ready;
  logic [AW-1:0] exu_rd;
  logic [DW-1:0] exu_data;
  logic          lsu_valid, lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          reg_wen;
  logic [AW-1:0] rd;
  logic [DW-1:0] reg_in;
  logic [AW-1:0] rs1, rs2;
  logic          hit1, hit2, idle;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .exu_valid (exu_valid),
    .exu_ready (exu_ready),
    .exu_rd    (exu_rd),
    .exu_data  (exu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .reg_wen   (reg_wen),
    .rd        (rd),
    .reg_in    (reg_in),
    .rs1       (rs1),
    .rs2       (rs2),
    .hit1      (hit1),
    .hit2      (hit2),
    .idle      (idle)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic [AW-1:0] e_rd, input logic [DW-1:0] e_data);
    check({tag, "_wen"}, 64'(reg_wen), 64'd1);
    check({tag, "_rd_data"}, 64'({rd, reg_in}), 64'({e_rd, e_data}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_exu(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    exu_valid = v; exu_rd = r; exu_data = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    lsu_valid = v; lsu_rd = r; lsu_data = d;
  endtask

  task automatic do_reset();
    drive_exu(1'b0, '0, '0);
    drive_lsu(1'b0, '0, '0);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ei, li, wcnt, cyc;
    logic started, gap, he, hl;
    logic [AW-1:0] e_rd;
    logic [DW-1:0] e_data;

    rs1 = 5'd5;
    rs2 = 5'd0;
    do_reset();

    // Reset state
    mid();
    check("rst_exu_ready", 64'(exu_ready), 64'd1);
    check("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    check("rst_hit1", 64'(hit1), 64'd0);
    check("rst_hit2", 64'(hit2), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_wen", 64'(reg_wen), 64'd0);
    check("rst_rd_data", 64'({rd, reg_in}), 64'd0);
    tick();

    // Single EXU write, rs1 watches rd 5
    drive_exu(1'b1, 5'd5, 32'h1234);
    mid();
    check("s_hs_ready", 64'(exu_ready), 64'd1);
    check("s_c0_idle", 64'(idle), 64'd1);
    tick();
    drive_exu(1'b0, '0, '0);
    mid();
    check("s_c1_wen", 64'(reg_wen), 64'd0);
    check("s_c1_idle", 64'(idle), 64'd0);
    check("s_c1_hit1", 64'(hit1), 64'd1);
    tick();
    mid();
    check_wr("s_c2", 5'd5, 32'h1234);
    check("s_c2_idle", 64'(idle), 64'd0);
    check("s_c2_hit1", 64'(hit1), 64'd1);
    tick();
    mid();
    check("s_c3_wen", 64'(reg_wen), 64'd0);
    check("s_c3_idle", 64'(idle), 64'd1);
    check("s_c3_hit1", 64'(hit1), 64'd0);
    tick();

    // First contention after reset: EXU wins
    do_reset();
    drive_exu(1'b1, 5'd3, 32'hA);
    drive_lsu(1'b1, 5'd4, 32'hB);
    mid();
    check("c_c0_exu_ready", 64'(exu_ready), 64'd1);
    check("c_c0_lsu_ready", 64'(lsu_ready), 64'd1);
    tick();
    drive_exu(1'b0, '0, '0);
    drive_lsu(1'b0, '0, '0);
    mid();
    check("c_c1_exu_ready", 64'(exu_ready), 64'd1);
    check("c_c1_lsu_stall", 64'(lsu_ready), 64'd0);
    tick();
    mid();
    check_wr("c_w0", 5'd3, 32'hA);
    check("c_c2_lsu_ready", 64'(lsu_ready), 64'd1);
    tick();
    mid();
    check_wr("c_w1", 5'd4, 32'hB);
    tick();
    // Lone EXU write makes EXU the most recent grant
    drive_exu(1'b1, 5'd6, 32'hC);
    tick();
    drive_exu(1'b0, '0, '0);
    tick();
    // Second simultaneous pair: LSU wins now
    drive_exu(1'b1, 5'd12, 32'h12);
    drive_lsu(1'b1, 5'd13, 32'h13);
    mid();
    check_wr("c_lone", 5'd6, 32'hC);
    tick();
    drive_exu(1'b0, '0, '0);
    drive_lsu(1'b0, '0, '0);
    mid();
    check("c2_exu_stall", 64'(exu_ready), 64'd0);
    check("c2_lsu_ready", 64'(lsu_ready), 64'd1);
    tick();
    mid();
    check_wr("c2_w0", 5'd13, 32'h13);
    tick();
    mid();
    check_wr("c2_w1", 5'd12, 32'h12);
    tick();
    mid();
    check("c2_end_wen", 64'(reg_wen), 64'd0);
    check("c2_end_idle", 64'(idle), 64'd1);
    tick();

    // Saturation: 8 requests per source, expect 16 alternating writes
    do_reset();
    ei = 0; li = 0; wcnt = 0; cyc = 0;
    started = 1'b0; gap = 1'b0;
    while (wcnt < 16 && cyc < 60) begin
      drive_exu(ei < 8, AW'(1 + ei), DW'(32'hE00 + ei));
      drive_lsu(li < 8, AW'(9 + li), DW'(32'hC00 + li));
      mid();
      he = exu_valid && exu_ready;
      hl = lsu_valid && lsu_ready;
      if (reg_wen) begin
        started = 1'b1;
        if (wcnt % 2 == 0) begin
          e_rd = AW'(1 + wcnt / 2);
          e_data = DW'(32'hE00 + wcnt / 2);
        end else begin
          e_rd = AW'(9 + wcnt / 2);
          e_data = DW'(32'hC00 + wcnt / 2);
        end
        check("sat_write", 64'({rd, reg_in}), 64'({e_rd, e_data}));
        wcnt++;
      end else if (started) begin
        gap = 1'b1;
      end
      tick();
      if (he) ei++;
      if (hl) li++;
      cyc++;
    end
    drive_exu(1'b0, '0, '0);
    drive_lsu(1'b0, '0, '0);
    check("sat_count", 64'(wcnt), 64'd16);
    check("sat_gap", 64'(gap), 64'd0);
    check("sat_exu_accepted", 64'(ei), 64'd8);
    check("sat_lsu_accepted", 64'(li), 64'd8);
    mid();
    check("sat_no_dup", 64'(reg_wen), 64'd0);
    check("sat_idle", 64'(idle), 64'd1);
    tick();

    // x0 drop
    rs1 = 5'd0;
    drive_exu(1'b1, 5'd0, 32'hFFFF);
    mid();
    check("x0_ready", 64'(exu_ready), 64'd1);
    check("x0_c0_idle", 64'(idle), 64'd1);
    tick();
    drive_exu(1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      mid();
      check("x0_wen", 64'(reg_wen), 64'd0);
      check("x0_hit1", 64'(hit1), 64'd0);
      check("x0_idle", 64'(idle), 64'd1);
      tick();
    end

    // Hazard window on LSU rd 7
    rs1 = 5'd8;
    rs2 = 5'd7;
    drive_lsu(1'b1, 5'd7, 32'h77);
    mid();
    check("hz_c0_hit2", 64'(hit2), 64'd0);
    tick();
    drive_lsu(1'b0, '0, '0);
    mid();
    check("hz_c1_hit2", 64'(hit2), 64'd1);
    check("hz_c1_hit1", 64'(hit1), 64'd0);
    tick();
    mid();
    check_wr("hz_c2", 5'd7, 32'h77);
    check("hz_c2_hit2", 64'(hit2), 64'd1);
    check("hz_c2_hit1", 64'(hit1), 64'd0);
    tick();
    mid();
    check("hz_c3_hit2", 64'(hit2), 64'd0);
    check("hz_c3_hit1", 64'(hit1), 64'd0);
    tick();

    // Mid-operation reset with both buffers full and a write on the port
    rs1 = 5'd22;
    rs2 = 5'd21;
    drive_exu(1'b1, 5'd20, 32'h20);
    tick();
    drive_exu(1'b1, 5'd22, 32'h22);
    drive_lsu(1'b1, 5'd21, 32'h21);
    mid();
    check("mr_c1_exu_ready", 64'(exu_ready), 64'd1);
    check("mr_c1_lsu_ready", 64'(lsu_ready), 64'd1);
    tick();
    drive_exu(1'b0, '0, '0);
    drive_lsu(1'b0, '0, '0);
    mid();
    check_wr("mr_c2", 5'd20, 32'h20);
    check("mr_c2_hit1", 64'(hit1), 64'd1);
    check("mr_c2_hit2", 64'(hit2), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("mr_async_wen", 64'(reg_wen), 64'd0);
    check("mr_async_rd_data", 64'({rd, reg_in}), 64'd0);
    check("mr_async_exu_ready", 64'(exu_ready), 64'd1);
    check("mr_async_lsu_ready", 64'(lsu_ready), 64'd1);
    check("mr_async_idle", 64'(idle), 64'd1);
    check("mr_async_hit1", 64'(hit1), 64'd0);
    #1 rst = 1'b1;
    tick();
    mid();
    check("mr_after_wen0", 64'(reg_wen), 64'd0);
    check("mr_after_idle", 64'(idle), 64'd1);
    tick();
    drive_exu(1'b1, 5'd1, 32'h1);
    drive_lsu(1'b1, 5'd2, 32'h2);
    mid();
    check("mr_after_wen1", 64'(reg_wen), 64'd0);
    tick();
    drive_exu(1'b0, '0, '0);
    drive_lsu(1'b0, '0, '0);
    mid();
    check("mr_lsu_stall", 64'(lsu_ready), 64'd0);
    tick();
    mid();
    check_wr("mr_w0", 5'd1, 32'h1);
    tick();
    mid();
    check_wr("mr_w1", 5'd2, 32'h2);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
